ariane_emc_apb_flash_rd: RTL and testbench
==========================================

// Module: ariane_emc_apb_flash_rd
// PURPOSE
// APB3 slave giving read-only access to async parallel NOR flash (BPI).
// Each 32-bit APB read becomes BEATS = 32/DATA_W flash accesses, with programmable access/turnaround timing.
// Optional flash_wait stretching has a timeout that reports pslverr.
// Sits between the peripheral APB crossbar and the board flash pins; successor to the fixed 16-bit dummy EMC.
// PARAMETERS
// ADDR_W        27  flash byte-address width; flash_a[0] always 0 when DATA_W=16
// DATA_W        16  flash data width; legal values 8, 16
// RD_WAIT       4   cycles ce_b/oe_b held low per beat before sampling; >=1
// T_TURN        1   cycles ce_b high after each beat (bus recovery); >=0
// USE_WAIT      0   1: extend ACCESS while flash_wait=1
// WAIT_TIMEOUT  64  max extension cycles per beat before error; >=1
// WR_ERR        1   1: APB writes get pslverr=1; 0: writes ignored, pslverr=0
// PORTS
// clk          in   1       clock
// rst          in   1       synchronous reset, active-high
// psel         in   1       APB select
// penable      in   1       APB access phase
// pwrite       in   1       APB direction
// paddr        in   32      APB byte address; only [ADDR_W-1:2] used
// pwdata       in   32      unused
// prdata       out  32      read data, registered
// pready       out  1       transfer complete, one-cycle pulse
// pslverr      out  1       error; meaningful only with pready
// flash_dq_i   in   DATA_W  flash data in
// flash_dq_o   out  DATA_W  tied 0
// flash_dq_t   out  DATA_W  tied all-1 (tristate, never drive)
// flash_a      out  ADDR_W  flash byte address
// flash_ce_b   out  1       chip enable, active-low
// flash_oe_b   out  1       output enable, active-low
// flash_we_b   out  1       tied 1
// flash_adv_b  out  1       tied 0 (async mode)
// flash_wait   in   1       flash busy, active-high; sampled only when USE_WAIT=1
// BEHAVIOUR
// Reset: state IDLE, prdata=0, pready=0, pslverr=0, ce_b=oe_b=1, flash_a=0, counters=0. A reset mid-access aborts next edge.
// FSM: IDLE -> ACCESS -> TURN -> (ACCESS of next beat | DONE) -> IDLE.
// IDLE: psel&penable&~pwrite -> latch paddr[ADDR_W-1:2], beat=0, go ACCESS.
//   psel&penable&pwrite -> go DONE; err=WR_ERR.
// ACCESS: ce_b=oe_b=0 (from registered state; no glitches).
//   flash_a = {addr_q, beat*(DATA_W/8)}, stable for the whole beat.
//   Count RD_WAIT cycles. On the last cycle, if USE_WAIT&flash_wait, stay and count the extension.
//   Otherwise sample flash_dq_i into prdata slice [beat*DATA_W +: DATA_W]; beat 0 = LSBs (little-endian).
//   Extension reaches WAIT_TIMEOUT -> err=1, no sample, skip remaining beats, go TURN then DONE.
// TURN: ce_b=oe_b=1, flash_a held, for T_TURN cycles; skipped when T_TURN=0.
//   Then go ACCESS with beat+1, or DONE after the last beat or on error.
// DONE: pready=1, pslverr=err for one cycle; on error prdata=0; -> IDLE, err cleared.
// Read latency (no wait): access phase seen in cycle 0 -> pready in cycle 1+BEATS*(RD_WAIT+T_TURN).
//   Defaults: cycle 11. Write: pready in cycle 1.
// pready=0 in every state except DONE, including IDLE. The slave never completes in the first access cycle.
// prdata holds the last completed read until the next read updates it. A write never changes prdata.
// psel dropping mid-transfer (protocol violation): the transfer still completes internally; no abort.
// Counters: RD_WAIT and WAIT_TIMEOUT counters sized $clog2(max+1); no wrap is possible (bounded by the FSM).
// STRUCTURE
// ariane_emc_pkg: state enum emc_state_e, function beats(DATA_W), parameter legality check.
//   An illegal DATA_W is an elaboration $error.
// Sub-module ariane_emc_timer: loadable down-counter with a zero flag.
//   Used for ACCESS, TURN and timeout counting; one instance, reloaded per state.
// TESTING
// Reset: rst=1 for 3 cycles during an ACCESS -> next cycle ce_b=oe_b=1, pready=0, prdata=0.
// Defaults, read 0x0000_1000, flash model returns 0xBEEF @0x1000 and 0xCAFE @0x1002
//   -> pready in cycle 11, prdata=0xCAFE_BEEF, pslverr=0, ce_b low for 4 cycles per beat.
// DATA_W=8, RD_WAIT=2, T_TURN=0, read 0x20, bytes 11,22,33,44 at 0x20..0x23
//   -> flash_a 0x20,0x21,0x22,0x23; prdata=0x4433_2211; pready in cycle 9.
// USE_WAIT=1, flash_wait high 5 cycles in beat 0 -> pready in cycle 16, data correct, pslverr=0.
// USE_WAIT=1, WAIT_TIMEOUT=8, flash_wait stuck high -> pready, pslverr=1, prdata=0; the next read succeeds.
// Write with WR_ERR=1 -> pready cycle 1, pslverr=1, prdata unchanged. With WR_ERR=0 -> pslverr=0.

Source files
------------

// File: rtl/ariane_emc_pkg.sv
// ariane_emc_pkg: shared types and elaboration helpers for the APB flash reader
package ariane_emc_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, TURN, DONE} emc_state_e;
  function automatic int beats(input int dw);
    return 32 / dw;
  endfunction
  function automatic bit dw_legal(input int dw);
    return dw == 8 || dw == 16;
  endfunction
  function automatic int max3(input int a, input int b, input int c);
    return (a > b ? (a > c ? a : c) : (b > c ? b : c));
  endfunction
endpackage

// File: rtl/ariane_emc_apb_flash_rd_if.sv
// ariane_emc_apb_flash_rd_if: APB3 bus bundle between crossbar and flash reader
interface ariane_emc_apb_flash_rd_if;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [31:0] paddr, pwdata, prdata;
  modport master (output psel, penable, pwrite, paddr, pwdata, input prdata, pready, pslverr);
  modport slave (input psel, penable, pwrite, paddr, pwdata, output prdata, pready, pslverr);
endinterface

// File: rtl/ariane_emc_timer.sv
// ariane_emc_timer: loadable down-counter that parks at zero and flags it
module ariane_emc_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic         zero
);
  logic [W-1:0] cnt;
  assign zero = cnt == '0;
  // reload on request, otherwise count down until zero
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= val;
    else if (!zero) cnt <= cnt - 1'b1;
endmodule

// File: rtl/ariane_emc_apb_flash_rd.sv
// ariane_emc_apb_flash_rd: read-only APB3 window onto async parallel NOR flash
module ariane_emc_apb_flash_rd
  import ariane_emc_pkg::*;
#(
  parameter int ADDR_W       = 27,
  parameter int DATA_W       = 16,
  parameter int RD_WAIT      = 4,
  parameter int T_TURN       = 1,
  parameter int USE_WAIT     = 0,
  parameter int WAIT_TIMEOUT = 64,
  parameter int WR_ERR       = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  ariane_emc_apb_flash_rd_if.slave apb,
  input  logic [DATA_W-1:0]    flash_dq_i,
  output logic [DATA_W-1:0]    flash_dq_o,
  output logic [DATA_W-1:0]    flash_dq_t,
  output logic [ADDR_W-1:0]    flash_a,
  output logic                 flash_ce_b,
  output logic                 flash_oe_b,
  output logic                 flash_we_b,
  output logic                 flash_adv_b,
  input  logic                 flash_wait
);
  localparam int BEATS = beats(DATA_W);
  localparam int TW = $clog2(max3(RD_WAIT, T_TURN, WAIT_TIMEOUT) + 1);
  localparam logic [TW-1:0] LD_ACC = TW'(RD_WAIT - 1);
  localparam logic [TW-1:0] LD_TURN = TW'(T_TURN - 1);
  localparam logic [TW-1:0] LD_TO = TW'(WAIT_TIMEOUT - 1);
  if (!dw_legal(DATA_W)) begin : g_bad_dw
    $error("ariane_emc_apb_flash_rd: DATA_W must be 8 or 16");
  end
  emc_state_e state, state_n;
  logic [ADDR_W-3:0] addr_q;
  logic [1:0] beat, beat_n;
  logic err, err_n, ext, ext_n, ld, zero, smp, clr, wt, last, unused;
  logic [TW-1:0] ld_val;
  logic [4:0] lsb;
  assign wt = USE_WAIT != 0 && flash_wait;
  assign last = beat == 2'(BEATS - 1);
  assign lsb = 5'(beat * DATA_W);
  assign flash_a = {addr_q, 2'(beat * (DATA_W / 8))};
  assign flash_dq_o = '0;
  assign flash_dq_t = '1;
  assign flash_we_b = 1'b1;
  assign flash_adv_b = 1'b0;
  assign unused = ^{apb.pwdata, apb.paddr[31:ADDR_W], apb.paddr[1:0]};
  ariane_emc_timer #(.W(TW)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (ld),
    .val  (ld_val),
    .zero (zero)
  );
  // next state, timer reloads, and beat sample / timeout strobes
  always_comb begin
    state_n = state;
    beat_n = beat;
    err_n = err;
    ext_n = ext;
    ld = 1'b0;
    ld_val = LD_ACC;
    smp = 1'b0;
    clr = 1'b0;
    unique case (state)
      IDLE:
        if (apb.psel && apb.penable) begin
          if (apb.pwrite) begin
            state_n = DONE;
            err_n = WR_ERR != 0;
          end else begin
            state_n = ACCESS;
            beat_n = '0;
            err_n = 1'b0;
            ext_n = 1'b0;
            ld = 1'b1;
          end
        end
      ACCESS:
        if (!ext && zero && wt) begin
          ext_n = 1'b1;
          ld = 1'b1;
          ld_val = LD_TO;
        end else if (zero || (ext && !wt)) begin
          ext_n = 1'b0;
          smp = !wt;
          clr = wt;
          err_n = wt;
          if (T_TURN > 0) begin
            state_n = TURN;
            ld = 1'b1;
            ld_val = LD_TURN;
          end else if (wt || last) state_n = DONE;
          else begin
            beat_n = beat + 1'b1;
            ld = 1'b1;
          end
        end
      TURN:
        if (zero) begin
          if (err || last) state_n = DONE;
          else begin
            state_n = ACCESS;
            beat_n = beat + 1'b1;
            ld = 1'b1;
          end
        end
      DONE: begin
        state_n = IDLE;
        err_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end
  // state plus registered bus/flash strobes derived from the next state
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      addr_q <= '0;
      beat <= '0;
      err <= 1'b0;
      ext <= 1'b0;
      apb.prdata <= '0;
      apb.pready <= 1'b0;
      apb.pslverr <= 1'b0;
      flash_ce_b <= 1'b1;
      flash_oe_b <= 1'b1;
    end else begin
      state <= state_n;
      beat <= beat_n;
      err <= err_n;
      ext <= ext_n;
      if (state == IDLE && apb.psel && apb.penable && !apb.pwrite) addr_q <= apb.paddr[ADDR_W-1:2];
      if (smp) apb.prdata[lsb +: DATA_W] <= flash_dq_i;
      else if (clr) apb.prdata <= '0;
      apb.pready <= state_n == DONE;
      apb.pslverr <= state_n == DONE && err_n;
      flash_ce_b <= state_n != ACCESS;
      flash_oe_b <= state_n != ACCESS;
    end
endmodule

// File: tb/tb_ariane_emc_apb_flash_rd.sv
// tb_ariane_emc_apb_flash_rd: three flash reader configurations against a timeline model
module tb_ariane_emc_apb_flash_rd;
  typedef struct packed {
    logic        act;
    logic [26:0] a;
    logic        rdy;
    logic        err;
    logic [31:0] data;
  } rec_t;
  localparam int DW [3] = '{16, 8, 16};
  localparam int RW [3] = '{4, 2, 4};
  localparam int TT [3] = '{1, 0, 1};
  localparam int UW [3] = '{0, 0, 1};
  localparam int WTO [3] = '{64, 64, 8};
  localparam int WRE [3] = '{1, 0, 1};
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic chk_on = 1'b0;
  int total = 0, bad = 0, cyc = 0, t0 = 0, sel = 0, wrel;
  logic [127:0] wpat = '0;
  logic flash_wait;
  logic [7:0] mem [0:4095];
  logic psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0;
  rec_t q [3][$];
  logic [31:0] last [3];
  logic rdy [3], err [3], ce [3], oe [3], we [3], adv [3];
  logic [31:0] prd [3];
  logic [26:0] fa [3];
  logic [15:0] dq0_i, dq0_o, dq0_t, dq2_i, dq2_o, dq2_t;
  logic [7:0] dq1_i, dq1_o, dq1_t;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  ariane_emc_apb_flash_rd_if bus0 ();
  ariane_emc_apb_flash_rd_if bus1 ();
  ariane_emc_apb_flash_rd_if bus2 ();
  assign bus0.psel = psel && sel == 0;
  assign bus1.psel = psel && sel == 1;
  assign bus2.psel = psel && sel == 2;
  assign {bus0.penable, bus0.pwrite, bus0.paddr, bus0.pwdata} = {penable, pwrite, paddr, 32'h0};
  assign {bus1.penable, bus1.pwrite, bus1.paddr, bus1.pwdata} = {penable, pwrite, paddr, 32'h0};
  assign {bus2.penable, bus2.pwrite, bus2.paddr, bus2.pwdata} = {penable, pwrite, paddr, 32'h0};
  assign {rdy[0], err[0], prd[0]} = {bus0.pready, bus0.pslverr, bus0.prdata};
  assign {rdy[1], err[1], prd[1]} = {bus1.pready, bus1.pslverr, bus1.prdata};
  assign {rdy[2], err[2], prd[2]} = {bus2.pready, bus2.pslverr, bus2.prdata};
  always_comb begin
    wrel = cyc - t0;
    flash_wait = (wrel >= 0 && wrel < 128) ? wpat[wrel[6:0]] : 1'b0;
    dq0_i = {mem[fa[0][11:0] + 12'd1], mem[fa[0][11:0]]};
    dq1_i = mem[fa[1][11:0]];
    dq2_i = {mem[fa[2][11:0] + 12'd1], mem[fa[2][11:0]]};
  end
  ariane_emc_apb_flash_rd u0 (
    .clk(clk), .rst(rst), .apb(bus0), .flash_dq_i(dq0_i), .flash_dq_o(dq0_o), .flash_dq_t(dq0_t),
    .flash_a(fa[0]), .flash_ce_b(ce[0]), .flash_oe_b(oe[0]), .flash_we_b(we[0]), .flash_adv_b(adv[0]),
    .flash_wait(flash_wait)
  );
  ariane_emc_apb_flash_rd #(.DATA_W(8), .RD_WAIT(2), .T_TURN(0), .WR_ERR(0)) u1 (
    .clk(clk), .rst(rst), .apb(bus1), .flash_dq_i(dq1_i), .flash_dq_o(dq1_o), .flash_dq_t(dq1_t),
    .flash_a(fa[1]), .flash_ce_b(ce[1]), .flash_oe_b(oe[1]), .flash_we_b(we[1]), .flash_adv_b(adv[1]),
    .flash_wait(flash_wait)
  );
  ariane_emc_apb_flash_rd #(.USE_WAIT(1), .WAIT_TIMEOUT(8)) u2 (
    .clk(clk), .rst(rst), .apb(bus2), .flash_dq_i(dq2_i), .flash_dq_o(dq2_o), .flash_dq_t(dq2_t),
    .flash_a(fa[2]), .flash_ce_b(ce[2]), .flash_oe_b(oe[2]), .flash_we_b(we[2]), .flash_adv_b(adv[2]),
    .flash_wait(flash_wait)
  );
  task automatic chk(input string nm, input int d, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s dut%0d got=%h exp=%h t=%0t", nm, d, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] fval(input int d, input logic [26:0] a);
    return d == 1 ? {24'h0, mem[a[11:0]]} : {16'h0, mem[a[11:0] + 12'd1], mem[a[11:0]]};
  endfunction
  // Builds the per-cycle expectation from transaction cycle 0 to the pready cycle.
  task automatic gen(input int d, input bit wr, input logic [31:0] addr, input logic [127:0] wp);
    rec_t r;
    int c, ext;
    bit to;
    logic [31:0] data;
    logic [26:0] a;
    q[d].push_back('0);
    r = '0;
    if (wr) begin
      r.rdy = 1'b1;
      r.err = WRE[d] != 0;
      r.data = last[d];
      q[d].push_back(r);
      return;
    end
    c = 1;
    data = '0;
    to = 1'b0;
    for (int b = 0; b < 32 / DW[d] && !to; b++) begin
      a = {addr[26:2], 2'b00} + 27'(b * DW[d] / 8);
      ext = 0;
      while (UW[d] != 0 && wp[c + RW[d] - 1 + ext] === 1'b1) begin
        if (ext == WTO[d]) begin
          to = 1'b1;
          break;
        end
        ext++;
      end
      r = '0;
      r.act = 1'b1;
      r.a = a;
      repeat (RW[d] + ext) begin
        q[d].push_back(r);
        c++;
      end
      if (!to) data |= fval(d, a) << (b * DW[d]);
      r = '0;
      repeat (TT[d]) begin
        q[d].push_back(r);
        c++;
      end
    end
    r = '0;
    r.rdy = 1'b1;
    r.err = to;
    r.data = to ? 32'h0 : data;
    q[d].push_back(r);
    last[d] = r.data;
  endtask
  // one compare process: every DUT against its expected timeline, or idle when none is pending
  always @(negedge clk)
    if (chk_on)
      for (int d = 0; d < 3; d++) begin
        rec_t r;
        if (q[d].size() > 0) begin
          r = q[d].pop_front();
          chk("pready", d, 32'(rdy[d]), 32'(r.rdy));
          chk("ce_b", d, 32'(ce[d]), 32'(!r.act));
          chk("oe_b", d, 32'(oe[d]), 32'(!r.act));
          if (r.act) chk("flash_a", d, 32'(fa[d]), 32'(r.a));
          if (r.rdy) begin
            chk("pslverr", d, 32'(err[d]), 32'(r.err));
            chk("prdata", d, prd[d], r.data);
          end
        end else begin
          chk("idle pready", d, 32'(rdy[d]), 32'h0);
          chk("idle ce_b", d, 32'(ce[d]), 32'h1);
          chk("idle oe_b", d, 32'(oe[d]), 32'h1);
          chk("idle prdata", d, prd[d], last[d]);
        end
      end
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [127:0] wp,
                      input int ecyc, input logic [31:0] edata, input bit eerr, input string nm);
    int rel;
    @(posedge clk);
    #1 sel = d;
    pwrite = wr;
    paddr = addr;
    psel = 1'b1;
    penable = 1'b0;
    @(posedge clk);
    #1 penable = 1'b1;
    t0 = cyc;
    wpat = wp;
    gen(d, wr, addr, wp);
    rel = 0;
    do begin
      @(negedge clk);
      rel = cyc - t0;
    end while (!rdy[d] && rel < 200);
    chk({nm, " latency"}, d, 32'(rel), 32'(ecyc));
    chk({nm, " prdata"}, d, prd[d], edata);
    chk({nm, " pslverr"}, d, 32'(err[d]), 32'(eerr));
    @(posedge clk);
    #1 psel = 1'b0;
    penable = 1'b0;
    wpat = '0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    {mem[3], mem[2], mem[1], mem[0]} = 32'hCAFE_BEEF;
    {mem[7], mem[6], mem[5], mem[4]} = 32'h1234_5678;
    {mem[35], mem[34], mem[33], mem[32]} = 32'h4433_2211;
    for (int d = 0; d < 3; d++) last[d] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_on = 1'b1;
    @(negedge clk);
    chk("reset prdata", 0, prd[0], 32'h0);
    chk("reset ce_b", 0, 32'(ce[0]), 32'h1);
    chk("tie dq_o", 0, 32'(dq0_o), 32'h0);
    chk("tie dq_t", 0, 32'(dq0_t), 32'hFFFF);
    chk("tie dq_o", 1, 32'(dq1_o), 32'h0);
    chk("tie dq_t", 1, 32'(dq1_t), 32'hFF);
    chk("tie dq_o", 2, 32'(dq2_o), 32'h0);
    chk("tie dq_t", 2, 32'(dq2_t), 32'hFFFF);
    chk("tie we_b", 0, 32'(we[0] & we[1] & we[2]), 32'h1);
    chk("tie adv_b", 0, 32'(adv[0] | adv[1] | adv[2]), 32'h0);
    xfer(0, 1'b0, 32'h1000, '0, 11, 32'hCAFE_BEEF, 1'b0, "read16");
    xfer(0, 1'b1, 32'h1000, '0, 1, 32'hCAFE_BEEF, 1'b1, "write err");
    xfer(1, 1'b0, 32'h20, '0, 9, 32'h4433_2211, 1'b0, "read8");
    xfer(1, 1'b1, 32'h20, '0, 1, 32'h4433_2211, 1'b0, "write quiet");
    xfer(2, 1'b0, 32'h1000, 128'h1F0, 16, 32'hCAFE_BEEF, 1'b0, "wait5");
    xfer(2, 1'b0, 32'h20, {128{1'b1}}, 14, 32'h0, 1'b1, "timeout");
    xfer(2, 1'b0, 32'h1004, '0, 11, 32'h1234_5678, 1'b0, "post timeout");
    @(posedge clk);
    #1 sel = 0;
    pwrite = 1'b0;
    paddr = 32'h1004;
    psel = 1'b1;
    penable = 1'b0;
    @(posedge clk);
    #1 penable = 1'b1;
    t0 = cyc;
    gen(0, 1'b0, 32'h1004, '0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst = 1'b1;
    psel = 1'b0;
    penable = 1'b0;
    @(posedge clk);
    #1 for (int d = 0; d < 3; d++) begin
      q[d].delete();
      last[d] = '0;
    end
    @(negedge clk);
    chk("abort ce_b", 0, 32'(ce[0]), 32'h1);
    chk("abort oe_b", 0, 32'(oe[0]), 32'h1);
    chk("abort pready", 0, 32'(rdy[0]), 32'h0);
    chk("abort prdata", 0, prd[0], 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    xfer(0, 1'b0, 32'h1004, '0, 11, 32'h1234_5678, 1'b0, "post reset");
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
